prog_seq: RTL

- Program sequencer that drives the register file's instruction/data interface: the producer end of the `instr`/`data_in` write protocol the register file consumes.
- Fetches 8-bit instructions from a synchronous program memory and decodes them.
- For ADD, runs a start/done handshake with the adder, then issues the write-back with the returned result.
- Sits between program memory, the adder and the register file in the proto-processor top level.

---
 rtl/prog_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/prog_seq.sv
// prog_seq: fetches 8-bit instructions, runs the adder handshake for ADD and issues register-file
// writes. Define PROG_SEQ_STEP_EN to add step_i single-step mode.
module prog_seq #(
  parameter int unsigned PC_W    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            main_enable,
`ifdef PROG_SEQ_STEP_EN
  input  logic            step_i,
`endif
  output logic [PC_W-1:0] pm_addr,
  input  logic [7:0]      pm_data,
  output logic [7:0]      instr,
  output logic [7:0]      data_out,
  output logic            wr_en,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [7:0]      alu_result,
  output logic            halted,
  output logic            error
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StWait, StWrite, StHalt
  } state_e;

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpJmp  = 2'b01;
  localparam logic [1:0] OpHalt = 2'b10;
  localparam logic [1:0] OpLoad = 2'b11;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      data_q, data_d;
  logic            error_q, error_d;
  logic            step_go;

  // Where WRITE and JMP resume: straight to FETCH, or back to IDLE to await a step pulse.
`ifdef PROG_SEQ_STEP_EN
  localparam state_e StResume = StIdle;
  assign step_go = step_i;
`else
  localparam state_e StResume = StFetch;
  assign step_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    data_d  = data_q;
    error_d = error_q;
    if (main_enable) begin
      unique case (state_q)
        StIdle:  if (step_go) state_d = StFetch;
        StFetch: state_d = StDecode;
        StDecode: begin
          instr_d = pm_data;
          unique case (pm_data[7:6])
            OpLoad: begin
              data_d  = {4'b0000, pm_data[3:0]};
              state_d = StWrite;
            end
            OpAdd:  state_d = StExec;
            OpJmp: begin
              pc_d    = pm_data[PC_W-1:0];
              state_d = StResume;
            end
            OpHalt: state_d = StHalt;
          endcase
        end
        StExec: begin
          cnt_d   = '0;
          state_d = StWait;
        end
        StWait: begin
          cnt_d = cnt_q + 8'd1;
          // A done arriving on the final allowed cycle still counts.
          if (alu_done) begin
            data_d  = alu_result;
            state_d = StWrite;
          end else if (cnt_q == CntLast) begin
            error_d = 1'b1;
            state_d = StHalt;
          end
        end
        StWrite: begin
          pc_d    = pc_q + PC_W'(1);
          state_d = StResume;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  // Strobes are gated by enable so a frozen EXEC/WRITE fires once after re-enable.
  assign wr_en     = main_enable && (state_q == StWrite);
  assign alu_start = main_enable && (state_q == StExec);
  assign halted    = (state_q == StHalt);
  assign pm_addr   = pc_q;
  assign instr     = instr_q;
  assign data_out  = data_q;
  assign error     = error_q;

endmodule
